// File: rtl/cabac_rice_esc_sched.sv
`default_nettype none
// ============================================================================
//  Module   : cabac_rice_esc_sched
//  Brief    : Per-coefficient-group escape scheduler for CABAC residual coding.
//             Accepts coefficients and issues Golomb-Rice jobs for the levels
//             that exceed the flag-coded base level. It also adapts the Rice
//             parameter and accumulates the escape bit cost of the group.
//  Revision : 1.0 - initial release
// ============================================================================
module cabac_rice_esc_sched #(
    parameter int MAX_RICE = 4,
    parameter int ACC_W    = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cg_start,
    input  logic [2:0]       init_rice,
    input  logic             coef_valid,
    output logic             coef_ready,
    input  logic [15:0]      abs_level,
    input  logic [1:0]       base_level,
    input  logic             coef_last,
    output logic             gr_start,
    output logic [15:0]      gr_symbol,
    output logic [15:0]      gr_rice,
    input  logic             gr_done,
    input  logic [15:0]      gr_total_bits,
    output logic [2:0]       rice_param,
    output logic             cg_done,
    output logic [ACC_W-1:0] cg_bits
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READY   = 2'd1,
        S_ISSUE   = 2'd2,
        S_WAIT_GR = 2'd3
    } state_t;

    // The sum is wide enough for both operands plus a carry.
    localparam logic [3:0]         c_MAX_RICE = 4'(MAX_RICE);
    localparam int                 c_SUM_W    = ((ACC_W > 16) ? ACC_W : 16) + 1;
    localparam logic [c_SUM_W-1:0] c_ACC_MAX  = {{(c_SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_rice;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_cg_bits;
    logic [15:0]        r_abs;
    logic [15:0]        r_sym;
    logic               r_last;
    logic               r_cg_done;

    logic               w_coef_ready;
    logic               w_gr_start;
    logic [18:0]        w_abs19;
    logic [18:0]        w_base19;
    logic [15:0]        w_sym;
    logic               w_escape;
    logic               w_accept;
    logic               w_gr_ret;
    logic [2:0]         w_init_rice;
    logic [18:0]        w_thr19;
    logic               w_bump;
    logic [3:0]         w_rice_inc;
    logic [2:0]         w_rice_nxt;
    logic [c_SUM_W-1:0] w_sum;
    logic [ACC_W-1:0]   w_acc_sat;

    // A base level of 0 is treated as 1 (every coded coefficient is non-zero).
    assign w_base19 = (base_level == 2'd0) ? 19'd1 : {17'd0, base_level};
    assign w_abs19  = {3'd0, abs_level};
    assign w_escape = (w_abs19 >= w_base19);
    // Only consumed when w_escape holds, so the difference is never negative.
    assign w_sym    = abs_level - w_base19[15:0];

    assign w_accept = (r_state == S_READY) && coef_valid;
    assign w_gr_ret = (r_state == S_WAIT_GR) && gr_done;

    assign w_init_rice = ({1'b0, init_rice} > c_MAX_RICE) ? c_MAX_RICE[2:0] : init_rice;

    // Adaptation threshold 3*2^k; 19 bits keeps the shift free of overflow.
    assign w_thr19    = 19'd3 << r_rice;
    assign w_bump     = ({3'd0, r_abs} > w_thr19);
    assign w_rice_inc = {1'b0, r_rice} + 4'd1;
    assign w_rice_nxt = (w_rice_inc > c_MAX_RICE) ? c_MAX_RICE[2:0] : w_rice_inc[2:0];

    assign w_sum     = c_SUM_W'(r_acc) + c_SUM_W'(gr_total_bits);
    assign w_acc_sat = (w_sum > c_ACC_MAX) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_coef_ready = 1'b0;
        w_gr_start   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cg_start) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                w_coef_ready = 1'b1;
                if (coef_valid) begin
                    if (w_escape) begin
                        w_state_nxt = S_ISSUE;
                    end else if (coef_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_ISSUE: begin
                w_gr_start  = 1'b1;
                w_state_nxt = S_WAIT_GR;
            end
            S_WAIT_GR: begin
                if (gr_done) begin
                    w_state_nxt = r_last ? S_IDLE : S_READY;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: Rice parameter, accumulator, captured job and completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rice    <= 3'd0;
            r_acc     <= '0;
            r_cg_bits <= '0;
            r_abs     <= 16'd0;
            r_sym     <= 16'd0;
            r_last    <= 1'b0;
            r_cg_done <= 1'b0;
        end else begin
            r_cg_done <= 1'b0;
            if ((r_state == S_IDLE) && cg_start) begin
                r_rice <= w_init_rice;
                r_acc  <= '0;
            end
            if (w_accept) begin
                if (w_escape) begin
                    r_abs  <= abs_level;
                    r_sym  <= w_sym;
                    r_last <= coef_last;
                end else if (coef_last) begin
                    r_cg_done <= 1'b1;
                    r_cg_bits <= r_acc;
                end
            end
            if (w_gr_ret) begin
                r_acc <= w_acc_sat;
                if (w_bump) begin
                    r_rice <= w_rice_nxt;
                end
                if (r_last) begin
                    r_cg_done <= 1'b1;
                    r_cg_bits <= w_acc_sat;
                end
            end
        end
    end

    assign coef_ready = w_coef_ready;
    assign gr_start   = w_gr_start;
    assign gr_symbol  = r_sym;
    assign gr_rice    = {13'd0, r_rice};
    assign rice_param = r_rice;
    assign cg_done    = r_cg_done;
    assign cg_bits    = r_cg_bits;

endmodule
`default_nettype wire

// File: tb/tb_cabac_rice_esc_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cabac_rice_esc_sched
//  Brief    : Directed self-checking bench for cabac_rice_esc_sched. A second
//             instance with a 4-bit accumulator shares all stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cabac_rice_esc_sched;

    logic        clk;
    logic        rst_n;
    logic        cg_start;
    logic [2:0]  init_rice;
    logic        coef_valid;
    logic [15:0] abs_level;
    logic [1:0]  base_level;
    logic        coef_last;
    logic        gr_done;
    logic [15:0] gr_total_bits;

    logic        coef_ready;
    logic        gr_start;
    logic [15:0] gr_symbol;
    logic [15:0] gr_rice;
    logic [2:0]  rice_param;
    logic        cg_done;
    logic [19:0] cg_bits;

    logic        coef_ready_s;
    logic        gr_start_s;
    logic [15:0] gr_symbol_s;
    logic [15:0] gr_rice_s;
    logic [2:0]  rice_param_s;
    logic        cg_done_s;
    logic [3:0]  cg_bits_s;

    int n_checks;
    int n_errors;

    cabac_rice_esc_sched #(.MAX_RICE(4), .ACC_W(20)) u_dut (
        .clk(clk), .rst_n(rst_n), .cg_start(cg_start), .init_rice(init_rice),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .abs_level(abs_level),
        .base_level(base_level), .coef_last(coef_last), .gr_start(gr_start),
        .gr_symbol(gr_symbol), .gr_rice(gr_rice), .gr_done(gr_done),
        .gr_total_bits(gr_total_bits), .rice_param(rice_param),
        .cg_done(cg_done), .cg_bits(cg_bits)
    );

    cabac_rice_esc_sched #(.MAX_RICE(4), .ACC_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .cg_start(cg_start), .init_rice(init_rice),
        .coef_valid(coef_valid), .coef_ready(coef_ready_s), .abs_level(abs_level),
        .base_level(base_level), .coef_last(coef_last), .gr_start(gr_start_s),
        .gr_symbol(gr_symbol_s), .gr_rice(gr_rice_s), .gr_done(gr_done),
        .gr_total_bits(gr_total_bits), .rice_param(rice_param_s),
        .cg_done(cg_done_s), .cg_bits(cg_bits_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cg(input logic [2:0] rice);
        cg_start  = 1'b1;
        init_rice = rice;
        tick();
        cg_start  = 1'b0;
        chk("start_ready", 32'(coef_ready), 32'd1);
    endtask

    task automatic send(input logic [15:0] a, input logic [1:0] b, input logic l);
        chk("send_ready", 32'(coef_ready), 32'd1);
        coef_valid = 1'b1;
        abs_level  = a;
        base_level = b;
        coef_last  = l;
        tick();
        coef_valid = 1'b0;
        coef_last  = 1'b0;
    endtask

    // Called in the ISSUE cycle: checks the job, waits one idle cycle, returns bits.
    task automatic gr_txn(input string tag, input logic [15:0] sym, input logic [15:0] rice,
                          input logic [15:0] bits);
        chk({tag, "_start"}, 32'(gr_start), 32'd1);
        chk({tag, "_sym"},   32'(gr_symbol), 32'(sym));
        chk({tag, "_rice"},  32'(gr_rice), 32'(rice));
        tick();
        chk({tag, "_start_off"}, 32'(gr_start), 32'd0);
        tick();
        chk({tag, "_sym_hold"}, 32'(gr_symbol), 32'(sym));
        gr_done       = 1'b1;
        gr_total_bits = bits;
        tick();
        gr_done       = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        cg_start      = 1'b0;
        init_rice     = 3'd0;
        coef_valid    = 1'b0;
        abs_level     = 16'd0;
        base_level    = 2'd0;
        coef_last     = 1'b0;
        gr_done       = 1'b0;
        gr_total_bits = 16'd0;
        tick();
        tick();
        chk("rst_ready",  32'(coef_ready), 32'd0);
        chk("rst_start",  32'(gr_start),   32'd0);
        chk("rst_done",   32'(cg_done),    32'd0);
        chk("rst_sym",    32'(gr_symbol),  32'd0);
        chk("rst_grrice", 32'(gr_rice),    32'd0);
        chk("rst_rice",   32'(rice_param), 32'd0);
        chk("rst_bits",   32'(cg_bits),    32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(coef_ready), 32'd0);

        // Two escapes: 4-1=3 at k=0 (4>3 bumps k), then 5-1=4 at k=1 (5<=6).
        start_cg(3'd0);
        send(16'd4, 2'd1, 1'b0);
        gr_txn("e1a", 16'd3, 16'd0, 16'd4);
        chk("e1a_ready", 32'(coef_ready), 32'd1);
        chk("e1a_rice",  32'(rice_param), 32'd1);
        chk("e1a_nodone", 32'(cg_done), 32'd0);
        send(16'd5, 2'd1, 1'b1);
        gr_txn("e1b", 16'd4, 16'd1, 16'd3);
        chk("e1_done", 32'(cg_done), 32'd1);
        chk("e1_bits", 32'(cg_bits), 32'd7);
        chk("e1_rice", 32'(rice_param), 32'd1);
        tick();
        chk("e1_pulse", 32'(cg_done), 32'd0);
        chk("e1_idle",  32'(coef_ready), 32'd0);
        chk("e1_hold",  32'(cg_bits), 32'd7);

        // Below-base last coefficient: no job, done next cycle with zero bits.
        start_cg(3'd0);
        chk("e2_rice_init", 32'(rice_param), 32'd0);
        send(16'd1, 2'd2, 1'b1);
        chk("e2_nostart", 32'(gr_start), 32'd0);
        chk("e2_done", 32'(cg_done), 32'd1);
        chk("e2_bits", 32'(cg_bits), 32'd0);
        chk("e2_idle", 32'(coef_ready), 32'd0);

        // Base 0 behaves as 1: abs 0 is no escape, abs 2 escapes with symbol 1.
        start_cg(3'd0);
        send(16'd0, 2'd0, 1'b0);
        chk("b0_nostart", 32'(gr_start), 32'd0);
        chk("b0_ready", 32'(coef_ready), 32'd1);
        send(16'd2, 2'd0, 1'b1);
        gr_txn("b0", 16'd1, 16'd0, 16'd5);
        chk("b0_done", 32'(cg_done), 32'd1);
        chk("b0_bits", 32'(cg_bits), 32'd5);
        chk("b0_rice", 32'(rice_param), 32'd0);

        // Rice saturation at MAX_RICE, and init clamp.
        start_cg(3'd4);
        send(16'd60, 2'd3, 1'b1);
        gr_txn("e3", 16'd57, 16'd4, 16'd2);
        chk("e3_rice", 32'(rice_param), 32'd4);
        chk("e3_done", 32'(cg_done), 32'd1);
        start_cg(3'd7);
        chk("e3_clamp", 32'(rice_param), 32'd4);
        send(16'd0, 2'd1, 1'b1);
        chk("e3_done2", 32'(cg_done), 32'd1);

        // Threshold boundary at k=2: 12 does not bump, 13 does.
        start_cg(3'd2);
        send(16'd12, 2'd1, 1'b0);
        gr_txn("th_a", 16'd11, 16'd2, 16'd1);
        chk("th_eq", 32'(rice_param), 32'd2);
        send(16'd13, 2'd1, 1'b1);
        gr_txn("th_b", 16'd12, 16'd2, 16'd1);
        chk("th_gt", 32'(rice_param), 32'd3);
        chk("th_bits", 32'(cg_bits), 32'd2);

        // Accumulator saturation: 10 + 9 = 19, clipped to 15 on the 4-bit instance.
        start_cg(3'd0);
        send(16'd4, 2'd1, 1'b0);
        gr_txn("s_a", 16'd3, 16'd0, 16'd10);
        send(16'd3, 2'd3, 1'b1);
        gr_txn("s_b", 16'd0, 16'd1, 16'd9);
        chk("s_bits_wide", 32'(cg_bits), 32'd19);
        chk("s_bits_sat",  32'(cg_bits_s), 32'd15);
        chk("s_done_sat",  32'(cg_done_s), 32'd1);

        // Reset during WAIT_GR aborts the group; the late gr_done is ignored.
        start_cg(3'd1);
        send(16'd8, 2'd1, 1'b0);
        chk("r_issue", 32'(gr_start), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("r_sym0",  32'(gr_symbol), 32'd0);
        chk("r_bits0", 32'(cg_bits), 32'd0);
        rst_n         = 1'b1;
        gr_done       = 1'b1;
        gr_total_bits = 16'd9;
        tick();
        gr_done       = 1'b0;
        chk("r_nodone", 32'(cg_done), 32'd0);
        chk("r_ready",  32'(coef_ready), 32'd0);
        chk("r_rice",   32'(rice_param), 32'd0);
        tick();
        chk("r_idle",   32'(coef_ready), 32'd0);
        chk("r_bits",   32'(cg_bits), 32'd0);

        // Stray cg_start / gr_done and held coef_valid outside their states.
        start_cg(3'd1);
        cg_start      = 1'b1;
        init_rice     = 3'd3;
        gr_done       = 1'b1;
        gr_total_bits = 16'd100;
        tick();
        cg_start = 1'b0;
        gr_done  = 1'b0;
        chk("i_rice",  32'(rice_param), 32'd1);
        chk("i_ready", 32'(coef_ready), 32'd1);
        chk("i_done",  32'(cg_done), 32'd0);
        send(16'd7, 2'd1, 1'b0);
        chk("i_issue", 32'(gr_start), 32'd1);
        chk("i_sym",   32'(gr_symbol), 32'd6);
        gr_done       = 1'b1;
        gr_total_bits = 16'd77;
        cg_start      = 1'b1;
        tick();
        gr_done    = 1'b0;
        cg_start   = 1'b1;
        coef_valid = 1'b1;
        abs_level  = 16'd50;
        base_level = 2'd1;
        coef_last  = 1'b1;
        tick();
        cg_start   = 1'b0;
        coef_valid = 1'b0;
        coef_last  = 1'b0;
        chk("i_wready", 32'(coef_ready), 32'd0);
        chk("i_wstart", 32'(gr_start), 32'd0);
        chk("i_wsym",   32'(gr_symbol), 32'd6);
        chk("i_wrice",  32'(gr_rice), 32'd1);
        gr_done       = 1'b1;
        gr_total_bits = 16'd5;
        tick();
        chk("i_ret_ready", 32'(coef_ready), 32'd1);
        chk("i_ret_rice",  32'(rice_param), 32'd2);
        chk("i_ret_done",  32'(cg_done), 32'd0);
        gr_total_bits = 16'd50;
        tick();
        gr_done = 1'b0;
        chk("i_stray_ready", 32'(coef_ready), 32'd1);
        send(16'd0, 2'd2, 1'b1);
        chk("i_done_end", 32'(cg_done), 32'd1);
        chk("i_bits_end", 32'(cg_bits), 32'd5);
        chk("i_rice_end", 32'(rice_param), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cabac_rice_esc_sched.md
CABAC_RICE_ESC_SCHED -- requirements
Module: cabac_rice_esc_sched

Interface
REQ-001 SHALL have parameter MAX_RICE, default 4, upper saturation limit of the Rice parameter.
REQ-002 SHALL have parameter ACC_W, default 20, width of the per-CG escape-bit accumulator.
REQ-003 SHALL have a single clock: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have reset: rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have cg_start  input  1  begin a coefficient group (CG); accepted only in IDLE.
REQ-006 SHALL have init_rice  input  3  initial Rice parameter, sampled on an accepted cg_start.
REQ-007 SHALL have coef_valid  input  1  coefficient offered.
REQ-008 SHALL have coef_ready  output  1  block can accept a coefficient.
REQ-009 SHALL have abs_level  input  16  absolute coefficient level.
REQ-010 SHALL have base_level  input  2  base level already covered by flags (1..3; 0 treated as 1).
REQ-011 SHALL have coef_last  input  1  marks the last coefficient of the CG.
REQ-012 SHALL have gr_start  output  1  one-cycle start pulse to the Golomb-Rice calculator.
REQ-013 SHALL have gr_symbol  output  16  escape symbol = abs_level - base_level.
REQ-014 SHALL have gr_rice  output  16  current Rice parameter, zero-extended.
REQ-015 SHALL have gr_done  input  1  Golomb-Rice result valid.
REQ-016 SHALL have gr_total_bits  input  16  escape bit cost returned with gr_done.
REQ-017 SHALL have rice_param  output  3  current Rice parameter.
REQ-018 SHALL have cg_done  output  1  one-cycle pulse when the CG completes.
REQ-019 SHALL have cg_bits  output  ACC_W  accumulated escape bits of the CG, valid with cg_done and held until the next cg_start.

Function
REQ-020 SHALL implement FSM states IDLE, READY, ISSUE, WAIT_GR.
REQ-021 IDLE: cg_start=1 -> READY; rice_param<=min(init_rice,MAX_RICE); accumulator<=0.
REQ-022 coef_ready SHALL be 1 only in READY.
REQ-023 A coefficient SHALL be accepted on a rising edge with coef_valid=1 and coef_ready=1.
REQ-024 Accepted coefficient with abs_level < base_level: no escape is generated and rice_param is unchanged.
REQ-025 For REQ-024, coef_last=1 SHALL pulse cg_done next cycle and go to IDLE; otherwise the FSM SHALL stay in READY.
REQ-026 Accepted coefficient with abs_level >= base_level: abs_level, symbol and last flag SHALL be registered and the FSM SHALL go to ISSUE.
REQ-027 ISSUE SHALL assert gr_start for exactly one cycle, then go to WAIT_GR.
REQ-028 gr_symbol and gr_rice SHALL remain stable from ISSUE until gr_done is sampled.
REQ-029 In WAIT_GR on gr_done=1, accumulator SHALL become min(acc+gr_total_bits, 2^ACC_W-1), saturating.
REQ-030 On the same edge, if stored abs_level > 3*(1<<rice_param), rice_param SHALL become min(rice_param+1,MAX_RICE).
REQ-031 On the same edge, stored last=1 SHALL pulse cg_done and go to IDLE; otherwise the FSM SHALL go to READY.
REQ-032 gr_done outside WAIT_GR SHALL be ignored.
REQ-033 cg_start outside IDLE SHALL be ignored.
REQ-034 Latency: escape acceptance to gr_start SHALL be 1 cycle; gr_done to coef_ready=1 (non-last) SHALL be 1 cycle.
REQ-035 Subtraction and comparison SHALL be unsigned, using 19-bit intermediates so that 3*(1<<4) does not overflow.

Reset
REQ-036 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-037 Under reset, coef_ready, gr_start, cg_done, gr_symbol, gr_rice, rice_param and cg_bits SHALL all be 0.
REQ-038 Reset in any state, including WAIT_GR, SHALL abort the CG without producing cg_done; a later gr_done SHALL be ignored.

Verification
REQ-039 init_rice=0; coefs (abs 4, base 1), then (abs 5, base 1, last); GR model returns 4 then 3 -> gr_symbol=3 with gr_rice=0, then gr_symbol=4 with gr_rice=1; cg_done with cg_bits=7; rice_param=1.
REQ-040 Coefficient abs 1, base 2, last -> no gr_start; cg_done the next cycle with cg_bits=0.
REQ-041 init_rice=4; abs 60, base 3 -> gr_symbol=57; rice_param stays 4 (saturated); init_rice=7 -> rice_param=4.
REQ-042 ACC_W=4; two escapes returning 10 and 9 -> cg_bits=15 (saturated).
REQ-043 rst_n=0 during WAIT_GR, then gr_done=1 -> no cg_done; coef_ready=0; state IDLE.
REQ-044 cg_start and stray gr_done pulsed during READY/WAIT_GR -> ignored; rice_param and accumulator unchanged; coef_valid held high in WAIT_GR -> no acceptance.
